// File: rtl/popcount_stream_acc_if.sv
// Stream-side bundle for popcount_stream_acc: beat input handshake plus
// the per-frame result handshake. The DUT uses slave; its driver uses master.
interface popcount_stream_acc_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 8
);
    logic                  clear_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] mask_i;
    logic                  mode_i;
    logic                  last_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [ACC_WIDTH-1:0]  total_o;
    logic [BEAT_WIDTH-1:0] beats_o;
    logic                  overflow_o;

    modport master (
        output clear_i, in_valid_i, data_i, mask_i, mode_i, last_i, out_ready_i,
        input  in_ready_o, out_valid_o, total_o, beats_o, overflow_o
    );

    modport slave (
        input  clear_i, in_valid_i, data_i, mask_i, mode_i, last_i, out_ready_i,
        output in_ready_o, out_valid_o, total_o, beats_o, overflow_o
    );
endinterface

// File: rtl/popcount_stream_acc.sv
// Frame-based Hamming-weight accumulator: per-beat masked popcount through a
// balanced adder tree, saturating per-frame totals, one result per frame.
module popcount_stream_acc #(
    parameter int DATA_WIDTH = 64,
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    popcount_stream_acc_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam int LEVELS    = $clog2(DATA_WIDTH);
    localparam int LEAVES    = 1 << LEVELS;

    logic [DATA_WIDTH-1:0] bits;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [ACC_WIDTH-1:0]  acc;
    logic [BEAT_WIDTH-1:0] beats;
    logic                  ovf;

    logic                  out_valid;
    logic [ACC_WIDTH-1:0]  total;
    logic [BEAT_WIDTH-1:0] beats_out;
    logic                  overflow;

    logic                  ready;
    logic                  accept;
    logic [ACC_WIDTH:0]    acc_sum;
    logic [BEAT_WIDTH:0]   beat_sum;
    logic [ACC_WIDTH-1:0]  acc_sat;
    logic [BEAT_WIDTH-1:0] beat_sat;
    logic                  sat_hit;

    assign bits = (bus.mode_i ? ~bus.data_i : bus.data_i) & bus.mask_i;

    // Level 0 holds one leaf per padded bit; each higher level halves the node count.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LEAVES >> l;
        logic [CNT_WIDTH-1:0] sum [N];
        for (genvar i = 0; i < N; i++) begin : g_node
            if (l == 0) begin : g_leaf
                if (i < DATA_WIDTH) begin : g_bit
                    assign sum[i] = CNT_WIDTH'(bits[i]);
                end else begin : g_pad
                    assign sum[i] = '0;
                end
            end else begin : g_add
                assign sum[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
            end
        end
    end

    assign cnt = g_lvl[LEVELS].sum[0];

    assign ready  = !bus.clear_i && (!out_valid || bus.out_ready_i);
    assign accept = bus.in_valid_i && ready;

    assign acc_sum  = {1'b0, acc} + (ACC_WIDTH + 1)'(cnt);
    assign beat_sum = {1'b0, beats} + (BEAT_WIDTH + 1)'(1);
    assign acc_sat  = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    assign beat_sat = beat_sum[BEAT_WIDTH] ? '1 : beat_sum[BEAT_WIDTH-1:0];
    assign sat_hit  = acc_sum[ACC_WIDTH] | beat_sum[BEAT_WIDTH];

    // A last beat accepted in the handshake cycle re-arms out_valid, so
    // back-to-back frames see no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc       <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            total     <= '0;
            beats_out <= '0;
            overflow  <= 1'b0;
        end else begin
            if (out_valid && bus.out_ready_i) begin
                out_valid <= 1'b0;
            end
            if (bus.clear_i) begin
                acc   <= '0;
                beats <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                if (bus.last_i) begin
                    total     <= acc_sat;
                    beats_out <= beat_sat;
                    overflow  <= ovf | sat_hit;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    beats     <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc   <= acc_sat;
                    beats <= beat_sat;
                    ovf   <= ovf | sat_hit;
                end
            end
        end
    end

    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = out_valid;
    assign bus.total_o     = total;
    assign bus.beats_o     = beats_out;
    assign bus.overflow_o  = overflow;
endmodule

// File: tb/tb_popcount_stream_acc.sv
// Directed bench for popcount_stream_acc: a vector table on a 16-bit instance
// plus multi-cycle sequences on 64-bit and narrow-accumulator instances.
module tb_popcount_stream_acc;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    popcount_stream_acc_if #(.DATA_WIDTH(64), .ACC_WIDTH(16), .BEAT_WIDTH(8)) bus64 ();
    popcount_stream_acc_if #(.DATA_WIDTH(16), .ACC_WIDTH(16), .BEAT_WIDTH(8)) bus16 ();
    popcount_stream_acc_if #(.DATA_WIDTH(64), .ACC_WIDTH(8),  .BEAT_WIDTH(2)) bus_sat ();

    popcount_stream_acc #(.DATA_WIDTH(64), .ACC_WIDTH(16), .BEAT_WIDTH(8)) dut64 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus64.slave)
    );
    popcount_stream_acc #(.DATA_WIDTH(16), .ACC_WIDTH(16), .BEAT_WIDTH(8)) dut16 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus16.slave)
    );
    popcount_stream_acc #(.DATA_WIDTH(64), .ACC_WIDTH(8), .BEAT_WIDTH(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus_sat.slave)
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] mask;
        logic        mode;
        int          exp_total;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        vecs[0] = '{16'h00FF, 16'hFFFF, 1'b1, 8};
        vecs[1] = '{16'h00FF, 16'hFFFF, 1'b0, 8};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b0, 0};
        vecs[3] = '{16'hA5A5, 16'hFFFF, 1'b0, 8};
        vecs[4] = '{16'hA5A5, 16'h0F0F, 1'b1, 4};
        vecs[5] = '{16'h8001, 16'hFFFF, 1'b0, 2};
        vecs[6] = '{16'h1234, 16'hFFFF, 1'b0, 5};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 0};
        vecs[8] = '{16'h0000, 16'hFFFF, 1'b1, 16};
        vecs[9] = '{16'h7FFF, 16'h00F0, 1'b0, 4};

        bus64.clear_i = 0; bus64.in_valid_i = 0; bus64.data_i = '0; bus64.mask_i = '0;
        bus64.mode_i = 0; bus64.last_i = 0; bus64.out_ready_i = 1;
        bus16.clear_i = 0; bus16.in_valid_i = 0; bus16.data_i = '0; bus16.mask_i = '0;
        bus16.mode_i = 0; bus16.last_i = 0; bus16.out_ready_i = 1;
        bus_sat.clear_i = 0; bus_sat.in_valid_i = 0; bus_sat.data_i = '0; bus_sat.mask_i = '0;
        bus_sat.mode_i = 0; bus_sat.last_i = 0; bus_sat.out_ready_i = 1;

        step();
        step();
        rst_i = 0;
        check("reset out_valid", 32'(bus64.out_valid_o), 0);
        check("reset total", 32'(bus64.total_o), 0);
        check("reset beats", 32'(bus64.beats_o), 0);
        check("reset overflow", 32'(bus64.overflow_o), 0);
        check("reset in_ready", 32'(bus64.in_ready_o), 1);

        // Single-beat frames, issued back to back.
        bus16.in_valid_i = 1;
        bus16.last_i = 1;
        for (int i = 0; i < 10; i++) begin
            bus16.data_i = vecs[i].data;
            bus16.mask_i = vecs[i].mask;
            bus16.mode_i = vecs[i].mode;
            step();
            check($sformatf("vec%0d out_valid", i), 32'(bus16.out_valid_o), 1);
            check($sformatf("vec%0d total", i), 32'(bus16.total_o), 32'(vecs[i].exp_total));
            check($sformatf("vec%0d beats", i), 32'(bus16.beats_o), 1);
            check($sformatf("vec%0d overflow", i), 32'(bus16.overflow_o), 0);
        end
        bus16.in_valid_i = 0;
        step();
        check("vec drain out_valid", 32'(bus16.out_valid_o), 0);

        // Three full beats on the 64-bit instance.
        bus64.in_valid_i = 1; bus64.data_i = '1; bus64.mask_i = '1; bus64.last_i = 0;
        step();
        step();
        bus64.last_i = 1;
        step();
        bus64.in_valid_i = 0;
        check("3beat out_valid", 32'(bus64.out_valid_o), 1);
        check("3beat total", 32'(bus64.total_o), 192);
        check("3beat beats", 32'(bus64.beats_o), 3);
        check("3beat overflow", 32'(bus64.overflow_o), 0);
        step();
        check("3beat drop", 32'(bus64.out_valid_o), 0);

        // Saturation of both total and beat count, then a clean frame.
        bus_sat.in_valid_i = 1; bus_sat.data_i = '1; bus_sat.mask_i = '1; bus_sat.last_i = 0;
        for (int i = 0; i < 4; i++) step();
        bus_sat.last_i = 1;
        step();
        check("sat total", 32'(bus_sat.total_o), 255);
        check("sat beats", 32'(bus_sat.beats_o), 3);
        check("sat overflow", 32'(bus_sat.overflow_o), 1);
        bus_sat.data_i = 64'h3;
        step();
        bus_sat.in_valid_i = 0;
        check("post-sat total", 32'(bus_sat.total_o), 2);
        check("post-sat beats", 32'(bus_sat.beats_o), 1);
        check("post-sat overflow", 32'(bus_sat.overflow_o), 0);

        // Backpressure holds the result; release takes the waiting last beat at once.
        bus64.out_ready_i = 0;
        bus64.in_valid_i = 1; bus64.last_i = 1; bus64.data_i = '1; bus64.mask_i = 64'hF;
        step();
        bus64.mask_i = 64'hFF;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d in_ready", i), 32'(bus64.in_ready_o), 0);
            check($sformatf("hold%0d out_valid", i), 32'(bus64.out_valid_o), 1);
            check($sformatf("hold%0d total", i), 32'(bus64.total_o), 4);
            step();
        end
        bus64.out_ready_i = 1;
        #1;
        check("release in_ready", 32'(bus64.in_ready_o), 1);
        step();
        bus64.in_valid_i = 0;
        check("release out_valid", 32'(bus64.out_valid_o), 1);
        check("release total", 32'(bus64.total_o), 8);
        check("release beats", 32'(bus64.beats_o), 1);
        step();
        check("release drop", 32'(bus64.out_valid_o), 0);

        // Clear aborts a partial frame and blocks a concurrent last beat.
        bus64.in_valid_i = 1; bus64.data_i = '1; bus64.mask_i = '1; bus64.last_i = 0;
        step();
        step();
        bus64.clear_i = 1; bus64.last_i = 1;
        #1;
        check("clear in_ready", 32'(bus64.in_ready_o), 0);
        step();
        bus64.clear_i = 0; bus64.data_i = 64'h3;
        check("clear no accept", 32'(bus64.out_valid_o), 0);
        step();
        bus64.in_valid_i = 0;
        check("clear total", 32'(bus64.total_o), 2);
        check("clear beats", 32'(bus64.beats_o), 1);
        check("clear overflow", 32'(bus64.overflow_o), 0);
        bus64.out_ready_i = 0; bus64.clear_i = 1;
        step();
        step();
        bus64.clear_i = 0;
        check("clear pending valid", 32'(bus64.out_valid_o), 1);
        check("clear pending total", 32'(bus64.total_o), 2);
        check("clear pending beats", 32'(bus64.beats_o), 1);

        // Reset drops a pending result and a partial frame.
        rst_i = 1;
        step();
        rst_i = 0;
        check("rst out_valid", 32'(bus64.out_valid_o), 0);
        check("rst total", 32'(bus64.total_o), 0);
        check("rst beats", 32'(bus64.beats_o), 0);
        check("rst overflow", 32'(bus64.overflow_o), 0);
        bus64.out_ready_i = 1;
        bus64.in_valid_i = 1; bus64.data_i = '1; bus64.mask_i = '1; bus64.last_i = 0;
        step();
        rst_i = 1;
        step();
        rst_i = 0;
        bus64.data_i = 64'h1; bus64.last_i = 1;
        step();
        bus64.in_valid_i = 0;
        check("rst acc total", 32'(bus64.total_o), 1);
        check("rst acc beats", 32'(bus64.beats_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
